// File: rtl/phys_reg_file_if.sv
// Bundles the write, allocate, flush and read signals of the physical register file.
// The master modport belongs to the rename/writeback side; the slave modport belongs to the file.
interface phys_reg_file_if #(
    parameter int unsigned NUM_REGS = 64,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned NUM_RD   = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic                     stall;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*IDX_W-1:0]  wr_idx;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     alloc_en;
    logic [IDX_W-1:0]         alloc_idx;
    logic                     flush;
    logic [NUM_RD*IDX_W-1:0]  rd_idx;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_ready;

    modport master (
        output stall, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, flush, rd_idx,
        input  rd_data, rd_ready
    );

    modport slave (
        input  stall, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, flush, rd_idx,
        output rd_data, rd_ready
    );
endinterface

// File: rtl/phys_reg_file.sv
// Physical register file with per-entry ready bits, multi-port writeback with same-cycle
// read bypass, rename allocation and flush recovery. Register 0 is hard-wired to zero and ready.
module phys_reg_file #(
    parameter int unsigned NUM_REGS = 64,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned NUM_RD   = 4
) (
    input logic            clk,
    input logic            reset,
    phys_reg_file_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] ready_q;
    logic [NUM_REGS-1:0] ready_d;

    // Ports are walked in ascending order so the highest-numbered writer lands last.
    always_comb begin
        mem_d   = mem_q;
        ready_d = ready_q;
        if (!bus.stall) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.wr_en[k]) begin
                    mem_d[bus.wr_idx[k*IDX_W +: IDX_W]]   = bus.wr_data[k*DATA_W +: DATA_W];
                    ready_d[bus.wr_idx[k*IDX_W +: IDX_W]] = 1'b1;
                end
            end
            // Allocation clears after the write sets; flush overrides both.
            if (bus.flush) begin
                ready_d = '1;
            end else if (bus.alloc_en) begin
                ready_d[bus.alloc_idx] = 1'b0;
            end
        end
        mem_d[0]   = '0;
        ready_d[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q   <= '{default: '0};
            ready_q <= '1;
        end else begin
            mem_q   <= mem_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              rdy;
        bus.rd_data  = '0;
        bus.rd_ready = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            idx  = bus.rd_idx[j*IDX_W +: IDX_W];
            data = mem_q[idx];
            rdy  = ready_q[idx];
            // Writes bypass to readers; allocations deliberately do not.
            if (!bus.stall) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (bus.wr_en[k] && (bus.wr_idx[k*IDX_W +: IDX_W] == idx)) begin
                        data = bus.wr_data[k*DATA_W +: DATA_W];
                        rdy  = 1'b1;
                    end
                end
            end
            if (!reset || (idx == '0)) begin
                data = '0;
                rdy  = 1'b1;
            end
            bus.rd_data[j*DATA_W +: DATA_W] = data;
            bus.rd_ready[j]                 = rdy;
        end
    end
endmodule

// File: doc/phys_reg_file.md
PHYS_REG_FILE -- requirements
Module: phys_reg_file

Interface
REQ-001 SHALL have parameter NUM_REGS, default 64, physical register count (power of two, >= 4).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter NUM_WR, default 2, write (writeback) port count.
REQ-004 SHALL have parameter NUM_RD, default 4, read port count.
REQ-005 SHALL derive IDX_W = clog2(NUM_REGS) as a local parameter.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 stall  input  1  high blocks all writes, allocations and flush; reads unaffected.
REQ-009 wr_en  input  NUM_WR  per-port write enable.
REQ-010 wr_idx  input  NUM_WR*IDX_W  per-port destination index, port k in bits [k*IDX_W +: IDX_W].
REQ-011 wr_data  input  NUM_WR*DATA_W  per-port write data, packed the same way.
REQ-012 alloc_en  input  1  rename allocated a new physical register this cycle.
REQ-013 alloc_idx  input  IDX_W  index being allocated.
REQ-014 flush  input  1  mispredict recovery; marks every register ready.
REQ-015 rd_idx  input  NUM_RD*IDX_W  per-port read index.
REQ-016 rd_data  output  NUM_RD*DATA_W  per-port read data, combinational.
REQ-017 rd_ready  output  NUM_RD  per-port ready (value produced) bit, combinational.

Function
REQ-018 SHALL hold NUM_REGS x DATA_W data entries and a NUM_REGS-bit ready vector.
REQ-019 Register 0 SHALL always read data 0 and ready 1; writes and allocations to index 0 SHALL be ignored.
REQ-020 On a rising edge with stall low, each port k with wr_en[k]=1 SHALL write wr_data[k] to entry wr_idx[k] and set its ready bit.
REQ-021 Same-cycle writes from several ports to one index: the highest-numbered port SHALL win; all other entries written independently.
REQ-022 On a rising edge with stall low and alloc_en=1, ready[alloc_idx] SHALL clear; data is left unchanged.
REQ-023 Alloc and write to the same index in one cycle: data SHALL take the write value, ready SHALL end at 0 (allocation wins).
REQ-024 flush=1 with stall low SHALL set all ready bits to 1 at the edge, overriding alloc_en in the same cycle; data writes in that cycle still occur.
REQ-025 With stall high, data and ready state SHALL hold regardless of wr_en, alloc_en and flush.
REQ-026 Reads SHALL be zero-latency: rd_data/rd_ready reflect stored state for rd_idx in the same cycle.
REQ-027 Write bypass: if stall low and any wr_en[k] targets rd_idx[j] (j any port), rd_data[j] SHALL return that cycle's winning write data and rd_ready[j] SHALL be 1, unless REQ-019 applies.
REQ-028 Alloc does not bypass: a same-cycle alloc_idx match SHALL NOT alter rd_ready for that cycle.
REQ-029 Indices are used modulo NUM_REGS; no out-of-range condition exists.

Reset
REQ-030 reset low SHALL asynchronously clear all data entries to 0 and set all ready bits to 1, independent of clk.
REQ-031 While reset is low, rd_data SHALL read 0 and rd_ready 1 on every port; reset deasserted mid-stream resumes normal operation at the next rising edge.

Verification
REQ-032 Reset then read idx 5 on all ports -> rd_data=0, rd_ready=1; alloc idx 5, next cycle -> rd_ready=0, rd_data=0.
REQ-033 Alloc idx 7; next cycle wr_en[0] idx 7 data 0xDEADBEEF with rd_idx[1]=7 -> same cycle rd_data[1]=0xDEADBEEF, rd_ready[1]=1; after edge the stored value persists.
REQ-034 Both write ports to idx 9, port0 0x1111, port1 0x2222 -> stored 0x2222, ready 1.
REQ-035 stall=1 with wr idx 3 data 0x55 and alloc idx 4 -> no bypass, idx 3 unchanged, ready[4] still 1 after edge.
REQ-036 Write idx 0 data 0xFFFF, alloc idx 0 -> idx 0 reads 0, ready 1; alloc idx 10 and 11, flush with alloc idx 12 -> ready 10/11/12 all 1.
REQ-037 Mid-run reset pulse asserted between edges -> all data 0, all ready 1 immediately, before the next clk edge.
